// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: fetch-side and decode-side valid/ready channels of the fetch queue.
interface inst_fetch_queue_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   modport master (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_inst
   );
   modport slave (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_inst
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular-buffer FIFO between fetch and decode, flushed on pipeline redirect.
module inst_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   inst_fetch_queue_if.slave        bus,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          enq;
   logic          deq;
   logic          empty;
   // occupancy comes from count alone, since wr_ptr == rd_ptr is ambiguous
   assign empty         = (count == '0);
   assign bus.in_ready  = (count != CW'(DEPTH));
   assign bus.out_valid = ~empty & ~flush;
   assign {bus.out_pc, bus.out_inst} = empty ? 64'h0 : mem[rd_ptr];
   assign enq = bus.in_valid & bus.in_ready & ~flush;
   assign deq = bus.out_valid & bus.out_ready;
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= enq ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= deq ? rd_ptr + AW'(1) : rd_ptr;
         count  <= count + CW'(enq) - CW'(deq);
      end
   end
   always_ff @(posedge clock) begin
      if (enq) mem[wr_ptr] <= {bus.in_pc, bus.in_inst};
   end
`ifndef SYNTHESIS
   logic [31:0] perf_full_cycles;
   logic [31:0] perf_empty_cycles;
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_full_cycles  <= '0;
         perf_empty_cycles <= '0;
      end else begin
         perf_full_cycles  <= perf_full_cycles + 32'(bus.in_valid & ~bus.in_ready);
         perf_empty_cycles <= perf_empty_cycles + 32'(empty);
      end
   end
`endif
endmodule
